// File: rtl/inst_encoder.sv
// RV32I instruction encoder with immediate checking and a small output FIFO.
// Packs opcode, register, funct and immediate fields into a 32-bit word. An immediate
// that is out of range or misaligned, or an illegal format, yields an addi x0,x0,0 NOP
// tagged with an error code. Results pass through one encode stage (s1) into a FIFO.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm  request fields
//   out_valid/out_ready        FIFO head handshake
//   out_inst, out_err, out_err_code  head entry (zero while empty)
//   enc_count, err_count       saturating counts of good / error words delivered
module inst_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  // Entry layout: {err, code[1:0], inst[31:0]}
  logic             s1_valid_q;
  logic [34:0]      s1_data_q;
  logic [34:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  fifo_count_q;
  logic [CntW:0]    occupancy;
  logic             accept, push, pop;
  logic [31:0]      enc_inst;
  logic [1:0]       enc_code;
  logic signed [31:0] imm_s;
  logic [34:0]      head;

  assign imm_s = in_imm;

  // Registered state only, so in_ready never depends on out_ready.
  assign occupancy = {1'b0, fifo_count_q} + {{CntW{1'b0}}, s1_valid_q};
  assign in_ready  = occupancy < (CntW + 1)'(DEPTH);
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid_q;
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid && out_ready;

  assign head         = mem_q[rd_ptr_q];
  assign out_inst     = out_valid ? head[31:0]  : '0;
  assign out_err_code = out_valid ? head[33:32] : '0;
  assign out_err      = out_valid ? head[34]    : 1'b0;

  // Field packing and immediate checks; misalignment is tested before range.
  always_comb begin
    enc_inst = '0;
    enc_code = 2'd0;
    case (in_fmt)
      3'd0: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_code = 2'd1;
      end
      3'd2: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_code = 2'd1;
      end
      3'd3: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
        if (in_imm[0])                                     enc_code = 2'd2;
        else if (imm_s < -32'sd4096 || imm_s > 32'sd4094) enc_code = 2'd1;
      end
      3'd4: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != 12'd0) enc_code = 2'd1;
      end
      3'd5: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])                                             enc_code = 2'd2;
        else if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574)   enc_code = 2'd1;
      end
      3'd6: begin
        enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (in_imm[31:5] != 27'd0) enc_code = 2'd1;
      end
      default: enc_code = 2'd3;
    endcase
    if (enc_code != 2'd0) enc_inst = Nop;
  end

  // Storage array carries no reset; out_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      enc_count    <= '0;
      err_count    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_data_q <= {enc_code != 2'd0, enc_code, enc_inst};
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_count_q <= fifo_count_q + 1'b1;
      else if (!push && pop) fifo_count_q <= fifo_count_q - 1'b1;
      if (pop && !head[34] && enc_count != '1) enc_count <= enc_count + 1'b1;
      if (pop && head[34]  && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic [CNT_W-1:0] enc_count, err_count;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int m_enc  = 0;
  int m_err  = 0;
  logic [34:0] exp_q[$];
  logic [34:0] done_q[$];
  logic [34:0] got_q[$];

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_err_code(out_err_code),
    .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: fields placed by shift/mask arithmetic, checks on integer ranges.
  function automatic logic [34:0] model(input int fmt, input int unsigned op, rd, rs1, rs2,
                                        f3, f7, input int unsigned imm);
    int signed   s;
    int          code;
    int unsigned w;
    s = int'(imm);
    code = 0;
    if (fmt == 7) code = 3;
    else if ((fmt == 3 || fmt == 5) && (imm & 1) != 0) code = 2;
    else if ((fmt == 1 || fmt == 2) && (s < -2048 || s > 2047)) code = 1;
    else if (fmt == 3 && (s < -4096 || s > 4094)) code = 1;
    else if (fmt == 5 && (s < -1048576 || s > 1048574)) code = 1;
    else if (fmt == 4 && (imm % 4096) != 0) code = 1;
    else if (fmt == 6 && imm > 31) code = 1;
    if (code != 0) return {1'b1, 2'(code), 32'h13};
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      2: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 31) << 7) | op;
      3: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
             | (((imm >> 11) & 1) << 7) | op;
      4: w = (imm & 32'hffff_f000) | (rd << 7) | op;
      5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
      default: w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endcase
    return {1'b0, 2'd0, w};
  endfunction

  // One clock: log accepts into the model and record DUT words at each output handshake.
  task automatic cycle();
    logic acc, pop, rst;
    logic [34:0] e;
    rst = reset;
    acc = in_valid && in_ready && !rst;
    pop = out_valid && out_ready && !rst;
    if (acc) begin
      exp_q.push_back(model(int'(in_fmt), in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
                            in_funct7, in_imm));
      n_acc++;
    end
    if (pop) begin
      got_q.push_back({out_err, out_err_code, out_inst});
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      done_q.push_back(e);
      if (e[34]) m_err = (m_err < CMAX) ? m_err + 1 : m_err;
      else       m_enc = (m_enc < CMAX) ? m_enc + 1 : m_enc;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_enc = 0;
      m_err = 0;
    end
  endtask

  task automatic rand_req();
    int edges[18] = '{-2049, -2048, 2047, 2048, -4098, -4096, 4094, 4096, 4095,
                      -1048578, -1048576, 1048574, 1048576, 1048575, 0, 1, 31, 32};
    in_fmt    = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    case ($urandom_range(0, 5))
      0: in_imm = $urandom;
      1: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2: in_imm = edges[$urandom_range(0, 17)];
      3: in_imm = (32'($urandom_range(0, 2200000)) - 32'd1100000) & ~32'd1;
      4: in_imm = $urandom & 32'hffff_f000;
      default: in_imm = 32'($urandom_range(0, 40));
    endcase
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (out_err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d want 0", out_err_code); end
    checks++; if (enc_count !== '0) begin errors++; $display("FAIL reset_enc_count got %0d want 0", enc_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  // Known-answer vectors, each sent alone to also check the two-cycle latency.
  task automatic test_directed();
    int          fmt[10] = '{1, 2, 3, 5, 0, 4, 6, 3, 1, 7};
    logic [6:0]  op [10] = '{7'h13, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h37, 7'h13, 7'h63, 7'h13, 7'h13};
    logic [4:0]  rd [10] = '{1, 0, 0, 1, 3, 5, 1, 0, 1, 1};
    logic [4:0]  rs1[10] = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    logic [4:0]  rs2[10] = '{0, 2, 0, 0, 2, 0, 0, 0, 0, 0};
    logic [2:0]  f3 [10] = '{0, 2, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [31:0] imm[10] = '{5, 8, -4, 32'h800, 0, 32'h1234_5000, 3, 3, 2048, 0};
    logic [31:0] ei [10] = '{32'h0050_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h0010_00EF,
                             32'h0020_81B3, 32'h1234_52B7, 32'h0030_9093, 32'h13, 32'h13,
                             32'h13};
    logic        ee [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [1:0]  ec [10] = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 3};
    for (int i = 0; i < 10; i++) begin
      in_fmt = 3'(fmt[i]); in_opcode = op[i]; in_rd = rd[i]; in_rs1 = rs1[i];
      in_rs2 = rs2[i]; in_funct3 = f3[i]; in_funct7 = 7'd0; in_imm = imm[i];
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, out_valid); end
      cycle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", i, out_valid); end
      checks++;
      if ({out_err, out_err_code, out_inst} !== {ee[i], ec[i], ei[i]}) begin
        errors++;
        $display("FAIL dir%0d_word got err=%b code=%0d inst=%h want err=%b code=%0d inst=%h",
                 i, out_err, out_err_code, out_inst, ee[i], ec[i], ei[i]);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end
    checks++; if (enc_count !== 4'd7) begin errors++; $display("FAIL dir_enc_count got %0d want 7", enc_count); end
    checks++; if (err_count !== 4'd3) begin errors++; $display("FAIL dir_err_count got %0d want 3", err_count); end
    got_q.delete(); done_q.delete();
  endtask

  task automatic test_backpressure();
    int a0;
    logic [34:0] g, e;
    got_q.delete(); done_q.delete();
    out_ready = 1'b0;
    a0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_req(); cycle(); end
    checks++; if (n_acc - a0 != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", n_acc - a0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain left %0d want 0", exp_q.size()); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = done_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_order got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    logic [34:0] g, e;
    got_q.delete(); done_q.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 30; i++) begin
      rand_req();
      cycle();
      checks++;
      if (exp_q.size() > DEPTH) begin errors++; $display("FAIL b2b_outstanding got %0d want <=%0d", exp_q.size(), DEPTH); end
    end
    checks++; if (n_acc - a0 < 18) begin errors++; $display("FAIL b2b_accepts got %0d want >=18", n_acc - a0); end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain left %0d want 0", exp_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = done_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_word got %h want %h", g, e); end
    end
    checks++; if (enc_count !== 4'(m_enc)) begin errors++; $display("FAIL b2b_enc_count got %0d want %0d", enc_count, m_enc); end
    checks++; if (err_count !== 4'(m_err)) begin errors++; $display("FAIL b2b_err_count got %0d want %0d", err_count, m_err); end
  endtask

  task automatic test_random();
    logic [34:0] g, e;
    got_q.delete(); done_q.delete();
    for (int i = 0; i < 400; i++) begin
      rand_req();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain left %0d want 0", exp_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = done_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rnd_word got %h want %h", g, e); end
    end
    checks++; if (enc_count !== 4'(m_enc)) begin errors++; $display("FAIL rnd_enc_count got %0d want %0d", enc_count, m_enc); end
    checks++; if (err_count !== 4'(m_err)) begin errors++; $display("FAIL rnd_err_count got %0d want %0d", err_count, m_err); end
  endtask

  task automatic test_reset_mid();
    int a0;
    got_q.delete(); done_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 6 && n_acc - a0 < 2; i++) begin rand_req(); cycle(); end
    in_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_buffered got %b want 1", out_valid); end
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    rand_req();
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
    checks++; if (enc_count !== '0) begin errors++; $display("FAIL rm_enc_count got %0d want 0", enc_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL rm_err_count got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale cycle %0d got %b want 0", i, out_valid); end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rm_stale_words got %0d want 0", got_q.size()); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
